pc_seq_ctrl: RTL
================

PC_SEQ_CTRL -- requirements
Module: pc_seq_ctrl

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-002 SHALL have parameter TRAP_VEC, default 32'h0000_0100, misaligned-target vector (used only under the configuration macro).
REQ-003 SHALL have port clk input 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rstn input 1, reset; asynchronous, active-low.
REQ-005 SHALL have port npc_op input 3, next-PC operation from EX, using the shared NPC_PLUS4/NPC_BRANCH/NPC_JUMP/NPC_JALR encodings.
REQ-006 SHALL have ports ex_pc input 32, ex_imm input 32, ex_aluout input 32: EX-stage PC, immediate, ALU result.
REQ-007 SHALL have port ex_valid input 1, EX holds a valid instruction.
REQ-008 SHALL have port hazard_stall input 1, load-use stall request from ID.
REQ-009 SHALL have port if_ready input 1, instruction memory accepts the current fetch.
REQ-010 SHALL have ports pc_out output 32 (fetch address) and if_req output 1 (fetch request).
REQ-011 SHALL have ports flush_ifid output 1 and flush_idex output 1, pipeline-register clear requests.
REQ-012 SHALL have port redirect_cnt output 16, saturating count of taken redirects.
REQ-013 SHALL have port trap_o output 1, one-cycle misaligned-target pulse; tied 0 when the macro is absent.

Function
REQ-014 SHALL implement states BOOT, RUN, PEND: BOOT->RUN unconditionally after one cycle; RUN->PEND on redirect while if_ready=0; PEND->RUN when if_ready=1.
REQ-015 SHALL treat a redirect as ex_valid=1 and npc_op in {BRANCH, JUMP, JALR}; all other codes are sequential.
REQ-016 SHALL compute target = ex_pc+ex_imm for BRANCH/JUMP and {ex_aluout[31:1],1'b0} for JALR, 32-bit wrap-around, no carry out.
REQ-017 SHALL drive if_req=0 in BOOT and 1 in RUN and PEND.
REQ-018 SHALL hold pc_out stable while if_req=1 and if_ready=0.
REQ-019 SHALL, in RUN with no redirect, hazard_stall=0 and if_ready=1, load pc_out+4 at the next edge.
REQ-020 SHALL, on redirect in RUN, assert flush_ifid and flush_idex combinationally in the same cycle and load target into pc_out at the next edge if if_ready=1; otherwise latch target into pend_pc and enter PEND.
REQ-021 SHALL, in PEND, keep pc_out unchanged; when if_ready=1, load pend_pc at the next edge and return to RUN.
REQ-022 SHALL give redirect priority over hazard_stall; a simultaneous stall is ignored.
REQ-023 SHALL, on hazard_stall without redirect, hold pc_out, assert flush_idex=1 and keep flush_ifid=0.
REQ-024 SHALL give the newer target priority when a redirect arrives in PEND: overwrite pend_pc and assert both flushes.
REQ-025 SHALL increment redirect_cnt once per accepted redirect and saturate at 16'hFFFF.

Reset
REQ-026 SHALL, while rstn=0: state=BOOT, pc_out=RESET_PC, pend_pc=0, redirect_cnt=0, if_req=0, flush_ifid=0, flush_idex=0, trap_o=0.
REQ-027 SHALL abandon any pending redirect when reset asserts in PEND; release returns to BOOT at RESET_PC.

Configuration
REQ-028 SHALL, with PC_MISALIGN_TRAP_EN defined: replace a target with target[1]=1 by TRAP_VEC, pulse trap_o for that cycle, and still assert both flushes.
REQ-029 SHALL, without PC_MISALIGN_TRAP_EN: force target[1:0] to 2'b00 and hold trap_o at 0.

Structure
REQ-030 SHALL take the NPC_* encodings and the state encoding from the shared ctrl_encode_def definitions; no local duplicates.
REQ-031 SHALL place target computation and misalignment check in sub-module pc_target_calc (combinational); the FSM, PC, pend_pc and counter live in pc_seq_ctrl.

Verification
REQ-032 SHALL verify reset release -> pc_out=0 and if_req=0 for one cycle, then 0x0, 0x4, 0x8 on successive cycles with if_ready=1.
REQ-033 SHALL verify BRANCH with ex_pc=0x40, ex_imm=0x20, if_ready=1 -> both flushes high that cycle, pc_out=0x60 next cycle, redirect_cnt=1.
REQ-034 SHALL verify JALR with ex_aluout=0x1235, if_ready=0 for 3 cycles -> PEND, pc_out unchanged, then 0x1234 the cycle after if_ready=1.
REQ-035 SHALL verify hazard_stall=1 together with JUMP (ex_pc=0x100, ex_imm=0x8) -> stall ignored, pc_out=0x108; stall alone -> pc_out held, only flush_idex=1.
REQ-036 SHALL verify JUMP target 0x102 -> macro defined: pc_out=0x100 (TRAP_VEC), trap_o=1; macro undefined: pc_out=0x100, trap_o=0.
REQ-037 SHALL verify 65540 redirects -> redirect_cnt=16'hFFFF; and rstn pulsed low in PEND -> pc_out=RESET_PC immediately.

Source files
------------

// File: rtl/ctrl_encode_def.sv
// Shared control encodings for the fetch/sequencing logic: next-PC operation
// codes, sequencer state encoding and the redirect counter ceiling.
package ctrl_encode_def;

  localparam logic [2:0] NPC_PLUS4  = 3'b000;
  localparam logic [2:0] NPC_BRANCH = 3'b001;
  localparam logic [2:0] NPC_JUMP   = 3'b010;
  localparam logic [2:0] NPC_JALR   = 3'b100;

  typedef enum logic [1:0] {
    ST_BOOT = 2'b00,
    ST_RUN  = 2'b01,
    ST_PEND = 2'b10
  } pc_state_e;

  localparam logic [15:0] REDIR_CNT_MAX = 16'hFFFF;

  // Only branch, jump and jalr change control flow; every other code is sequential.
  function automatic logic is_redirect_op(input logic [2:0] op);
    return (op == NPC_BRANCH) || (op == NPC_JUMP) || (op == NPC_JALR);
  endfunction

endpackage

// File: rtl/pc_target_calc.sv
// Redirect target computation and misalignment handling (combinational).
// Optional feature macro: PC_MISALIGN_TRAP_EN -- when defined, a target with
// bit 1 set is replaced by TRAP_VEC and flagged; otherwise the target is
// simply forced to word alignment and never flagged.
module pc_target_calc
  import ctrl_encode_def::*;
#(
  parameter logic [31:0] TRAP_VEC = 32'h0000_0100
) (
  input  logic [2:0]  npc_op,
  input  logic [31:0] ex_pc,
  input  logic [31:0] ex_imm,
  input  logic [31:0] ex_aluout,
  output logic [31:0] target_o,
  output logic        misalign_o
);

  logic [31:0] raw_target;

  // The trap vector itself must be a legal word-aligned fetch address.
  if (TRAP_VEC[1:0] != 2'b00) begin : g_bad_trap_vec
    $error("pc_target_calc: TRAP_VEC must be word aligned");
  end

  // jalr clears bit 0 of the ALU result; branch/jump add the immediate to the EX pc.
  always_comb begin
    if (npc_op == NPC_JALR) begin
      raw_target = ex_aluout & 32'hFFFF_FFFE;
    end else begin
      raw_target = ex_pc + ex_imm;
    end
  end

`ifdef PC_MISALIGN_TRAP_EN
  // Misaligned (bit 1 set) targets are diverted to the trap vector.
  always_comb begin
    misalign_o = raw_target[1];
    target_o   = raw_target[1] ? TRAP_VEC : raw_target;
  end
`else
  // Without trapping, drop the low bits so fetch stays word aligned.
  always_comb begin
    misalign_o = 1'b0;
    target_o   = raw_target & 32'hFFFF_FFFC;
  end
`endif

endmodule

// File: rtl/pc_seq_ctrl.sv
// Fetch PC sequencer: boot/run/pending FSM, fetch PC, pending redirect
// target, pipeline flush requests and a saturating redirect counter.
// Optional feature macro: PC_MISALIGN_TRAP_EN (handled in pc_target_calc;
// trap_o is constant 0 when it is not defined).
module pc_seq_ctrl
  import ctrl_encode_def::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] TRAP_VEC = 32'h0000_0100
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [2:0]  npc_op,
  input  logic [31:0] ex_pc,
  input  logic [31:0] ex_imm,
  input  logic [31:0] ex_aluout,
  input  logic        ex_valid,
  input  logic        hazard_stall,
  input  logic        if_ready,
  output logic [31:0] pc_out,
  output logic        if_req,
  output logic        flush_ifid,
  output logic        flush_idex,
  output logic [15:0] redirect_cnt,
  output logic        trap_o
);

  pc_state_e   state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] pend_pc_q, pend_pc_d;
  logic [15:0] cnt_q, cnt_d;

  logic [31:0] target;
  logic        misalign;
  logic        redirect;
  logic        accept;

  pc_target_calc #(
    .TRAP_VEC (TRAP_VEC)
  ) u_target (
    .npc_op     (npc_op),
    .ex_pc      (ex_pc),
    .ex_imm     (ex_imm),
    .ex_aluout  (ex_aluout),
    .target_o   (target),
    .misalign_o (misalign)
  );

  assign redirect     = ex_valid && is_redirect_op(npc_op);
  assign pc_out       = pc_q;
  assign redirect_cnt = cnt_q;

  // State, PC, pending target and counter registers; reset abandons any pending redirect.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= ST_BOOT;
      pc_q      <= RESET_PC;
      pend_pc_q <= 32'h0000_0000;
      cnt_q     <= 16'h0000;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      pend_pc_q <= pend_pc_d;
      cnt_q     <= cnt_d;
    end
  end

  // Next-state, next-PC and flush/trap outputs; redirects outrank stalls.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    pend_pc_d  = pend_pc_q;
    cnt_d      = cnt_q;
    if_req     = 1'b0;
    flush_ifid = 1'b0;
    flush_idex = 1'b0;
    trap_o     = 1'b0;
    accept     = 1'b0;

    unique case (state_q)
      ST_BOOT: begin
        // Nothing is in flight yet, so EX inputs are ignored for this cycle.
        state_d = ST_RUN;
      end

      ST_RUN: begin
        if_req = 1'b1;
        if (redirect) begin
          accept = 1'b1;
          if (if_ready) begin
            pc_d = target;
          end else begin
            // Current fetch not accepted: keep pc_out stable, remember the target.
            pend_pc_d = target;
            state_d   = ST_PEND;
          end
        end else if (hazard_stall) begin
          flush_idex = 1'b1;
        end else if (if_ready) begin
          pc_d = pc_q + 32'd4;
        end
      end

      ST_PEND: begin
        if_req = 1'b1;
        if (redirect) begin
          // A newer redirect supersedes the one still waiting.
          accept = 1'b1;
          if (if_ready) begin
            pc_d    = target;
            state_d = ST_RUN;
          end else begin
            pend_pc_d = target;
          end
        end else begin
          flush_idex = hazard_stall;
          if (if_ready) begin
            pc_d    = pend_pc_q;
            state_d = ST_RUN;
          end
        end
      end

      default: begin
        state_d = ST_BOOT;
      end
    endcase

    if (accept) begin
      flush_ifid = 1'b1;
      flush_idex = 1'b1;
      trap_o     = misalign;
      if (cnt_q != REDIR_CNT_MAX) begin
        cnt_d = cnt_q + 16'd1;
      end
    end
  end

endmodule
